// File: rtl/asg_bank_swap_ctrl.sv
// Ping-pong DAC bank scheduler: swaps banks on table-pass boundaries.
// Define ASG_SWAP_UNDERRUN_STOP_EN to halt playback on underrun.
module asg_bank_swap_ctrl #(
  parameter int CYC_W  = 16,
  parameter int UCNT_W = 16
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              commit_i,
  input  logic              trig_i,
  input  logic              cyc_end_i,
  input  logic [CYC_W-1:0]  ncyc_i,
  output logic              rd_bank_o,
  output logic              wr_bank_o,
  output logic              swap_o,
  output logic              busy_o,
  output logic              shadow_full_o,
  output logic              underrun_o,
  output logic              ovr_o,
  output logic [UCNT_W-1:0] urun_cnt_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

`ifdef ASG_SWAP_UNDERRUN_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  localparam logic [UCNT_W-1:0] UMAX = '1;

  logic [1:0]        state_q, state_d;
  logic              rd_q, rd_d;
  logic              swap_q, swap_d;
  logic              sh_q, sh_d;
  logic              ur_q, ur_d;
  logic              ovr_q, ovr_d;
  logic [UCNT_W-1:0] cnt_q, cnt_d;
  logic [UCNT_W-1:0] cnt_base;
  logic [CYC_W-1:0]  pass_q, pass_d;

  logic [CYC_W:0] limit;
  logic [CYC_W:0] pass_inc;
  logic           in_idle, in_wait, in_play;
  logic           at_swap, play_swap, urun_ev;
  logic           idle_commit, commit_st, ovr_ev;

  assign in_idle = en_i & (state_q == S_IDLE);
  assign in_wait = en_i & (state_q == S_WAIT);
  assign in_play = en_i & (state_q == S_PLAY);

  // Extra bit keeps pass_cnt+1 from wrapping in the compare
  assign limit    = (ncyc_i == '0) ? {{CYC_W{1'b0}}, 1'b1}
                                   : {1'b0, ncyc_i};
  assign pass_inc = {1'b0, pass_q} + 1'b1;

  assign at_swap     = in_play & cyc_end_i & (pass_inc >= limit);
  assign play_swap   = at_swap & (sh_q | commit_i);
  assign urun_ev     = at_swap & ~(sh_q | commit_i);
  assign idle_commit = in_idle & commit_i;
  assign commit_st   = commit_i & (in_wait | (in_play & ~play_swap));
  assign ovr_ev      = commit_st & sh_q;

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (commit_i) state_d = S_WAIT;
        S_WAIT:  if (trig_i) state_d = S_PLAY;
        S_PLAY:  if (urun_ev && STOP) state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q == S_PLAY);
    state_o = state_q;
  end

  always_comb begin
    rd_d   = rd_q ^ (idle_commit | play_swap);
    swap_d = idle_commit | play_swap;

    sh_d = sh_q;
    if (!en_i || play_swap) sh_d = 1'b0;
    else if (commit_st)     sh_d = 1'b1;

    pass_d = pass_q;
    if (!en_i)                   pass_d = '0;
    else if (in_wait && trig_i)  pass_d = '0;
    else if (at_swap)            pass_d = '0;
    else if (in_play && cyc_end_i) pass_d = pass_inc[CYC_W-1:0];

    // A coinciding clear is applied first so the new event survives
    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (urun_ev && cnt_base != UMAX) cnt_d = cnt_base + 1'b1;

    ur_d  = urun_ev | (ur_q & ~clr_i);
    ovr_d = ovr_ev | (ovr_q & ~clr_i);
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      rd_q   <= 1'b0;
      swap_q <= 1'b0;
      sh_q   <= 1'b0;
      ur_q   <= 1'b0;
      ovr_q  <= 1'b0;
      cnt_q  <= '0;
      pass_q <= '0;
    end else begin
      rd_q   <= rd_d;
      swap_q <= swap_d;
      sh_q   <= sh_d;
      ur_q   <= ur_d;
      ovr_q  <= ovr_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
    end
  end

  assign rd_bank_o     = rd_q;
  assign wr_bank_o     = ~rd_q;
  assign swap_o        = swap_q;
  assign shadow_full_o = sh_q;
  assign underrun_o    = ur_q;
  assign ovr_o         = ovr_q;
  assign urun_cnt_o    = cnt_q;

endmodule

// File: tb/tb_asg_bank_swap_ctrl.sv
// Bench for asg_bank_swap_ctrl: directed vector table plus random run
// against a behavioural model of the bank scheduling rules.
module tb_asg_bank_swap_ctrl;

  localparam int CW = 16;
  localparam int UW = 2;
  localparam int OW = 9 + UW;
  localparam int UMAXI = (1 << UW) - 1;

`ifdef ASG_SWAP_UNDERRUN_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en, clr, commit, trig, cyc;
  logic [CW-1:0] ncyc;
  logic          rd_bank_o, wr_bank_o, swap_o, busy_o;
  logic          shadow_full_o, underrun_o, ovr_o;
  logic [UW-1:0] urun_cnt_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  asg_bank_swap_ctrl #(.CYC_W(CW), .UCNT_W(UW)) dut (
    .dac_clk_i     (clk),
    .dac_rst_i     (rst),
    .en_i          (en),
    .clr_i         (clr),
    .commit_i      (commit),
    .trig_i        (trig),
    .cyc_end_i     (cyc),
    .ncyc_i        (ncyc),
    .rd_bank_o     (rd_bank_o),
    .wr_bank_o     (wr_bank_o),
    .swap_o        (swap_o),
    .busy_o        (busy_o),
    .shadow_full_o (shadow_full_o),
    .underrun_o    (underrun_o),
    .ovr_o         (ovr_o),
    .urun_cnt_o    (urun_cnt_o),
    .state_o       (state_o)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic          en, clr, commit, trig, cyc;
    logic [CW-1:0] ncyc;
    int            gap;
    logic          rd, sw, bs, sh, ur, ov;
    logic [UW-1:0] cnt;
    logic [1:0]    st;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic en_, clr_, com_, trg_, cyc_,
    input int nc, gp,
    input logic rd_, sw_, bs_, sh_, ur_, ov_,
    input int cn, st_);
    vec_t v;
    v.en = en_; v.clr = clr_; v.commit = com_;
    v.trig = trg_; v.cyc = cyc_;
    v.ncyc = CW'(nc); v.gap = gp;
    v.rd = rd_; v.sw = sw_; v.bs = bs_; v.sh = sh_;
    v.ur = ur_; v.ov = ov_;
    v.cnt = UW'(cn); v.st = 2'(st_);
    return v;
  endfunction

  function automatic logic [OW-1:0] pack(
    input logic r, s, b, h, u, o,
    input logic [UW-1:0] c, input logic [1:0] st);
    return {r, ~r, s, b, h, u, o, c, st};
  endfunction

  task automatic check(input string nm, input logic [OW-1:0] exp);
    logic [OW-1:0] act;
    act = {rd_bank_o, wr_bank_o, swap_o, busy_o, shadow_full_o,
           underrun_o, ovr_o, urun_cnt_o, state_o};
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b (rd wr sw bs sh ur ov cnt st)",
               nm, act, exp);
    end
  endtask

  task automatic idle_in(input logic e, input logic [CW-1:0] n);
    en = e; clr = 0; commit = 0; trig = 0; cyc = 0; ncyc = n;
  endtask

  // Behavioural model of the scheduling rules
  int   m_st, m_pass, m_cnt;
  logic m_rd, m_sh, m_ur, m_ov, m_sw;

  task automatic model_reset();
    m_st = 0; m_pass = 0; m_cnt = 0;
    m_rd = 0; m_sh = 0; m_ur = 0; m_ov = 0; m_sw = 0;
  endtask

  task automatic model_step();
    int lim;
    m_sw = 0;
    if (clr) begin m_ur = 0; m_ov = 0; m_cnt = 0; end
    if (!en) begin
      m_st = 0; m_sh = 0; m_pass = 0;
    end else if (m_st == 0) begin
      if (commit) begin m_rd = !m_rd; m_sw = 1; m_st = 1; end
    end else if (m_st == 1) begin
      if (commit) begin
        if (m_sh) m_ov = 1; else m_sh = 1;
      end
      if (trig) begin m_st = 2; m_pass = 0; end
    end else begin
      lim = (ncyc == 0) ? 1 : int'(ncyc);
      if (cyc && m_pass + 1 >= lim) begin
        if (m_sh || commit) begin
          m_rd = !m_rd; m_sw = 1; m_sh = 0;
        end else begin
          m_ur = 1;
          m_cnt = (m_cnt < UMAXI) ? m_cnt + 1 : UMAXI;
          if (STOP) m_st = 1;
        end
        m_pass = 0;
      end else begin
        if (cyc) m_pass++;
        if (commit) begin
          if (m_sh) m_ov = 1; else m_sh = 1;
        end
      end
    end
  endtask

  initial begin
    logic b1;
    int   s1;
    b1 = STOP ? 1'b0 : 1'b1;
    s1 = STOP ? 1 : 2;

    // en cl co tr cy nc gap   rd sw bs sh ur ov cnt st
    tv.push_back(mk(1,0,1,0,0, 3,  0,  1,1,0,0,0,0, 0,1));
    tv.push_back(mk(1,0,0,0,0, 3,  0,  1,0,0,0,0,0, 0,1));
    tv.push_back(mk(1,0,0,1,0, 3,  0,  1,0,1,0,0,0, 0,2));
    tv.push_back(mk(1,0,1,0,0, 3,  0,  1,0,1,1,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,1, 3,100,  1,0,1,1,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,1, 3,100,  1,0,1,1,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,1, 3,100,  0,1,1,0,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,0, 2,  0,  0,0,1,0,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,1, 2,  0,  0,0,1,0,0,0, 0,2));
    tv.push_back(mk(1,0,0,0,1, 2,  0,  0,0,b1,0,1,0,1,s1));
    tv.push_back(mk(1,0,0,1,0, 2,  0,  0,0,1,0,1,0, 1,2));
    tv.push_back(mk(1,0,0,0,1, 2,  0,  0,0,1,0,1,0, 1,2));
    tv.push_back(mk(1,0,1,0,1, 2,  0,  1,1,1,0,1,0, 1,2));
    tv.push_back(mk(1,0,1,0,0, 2,  0,  1,0,1,1,1,0, 1,2));
    tv.push_back(mk(1,0,1,0,0, 2,  0,  1,0,1,1,1,1, 1,2));
    tv.push_back(mk(1,0,0,0,1, 0,  0,  0,1,1,0,1,1, 1,2));
    tv.push_back(mk(1,0,0,0,1, 0,  0,  0,0,b1,0,1,1,2,s1));
    tv.push_back(mk(1,0,0,1,0, 0,  0,  0,0,1,0,1,1, 2,2));
    tv.push_back(mk(1,0,0,0,1, 0,  0,  0,0,b1,0,1,1,3,s1));
    tv.push_back(mk(1,0,0,1,0, 0,  0,  0,0,1,0,1,1, 3,2));
    tv.push_back(mk(1,0,0,0,1, 0,  0,  0,0,b1,0,1,1,3,s1));
    tv.push_back(mk(1,0,0,1,0, 0,  0,  0,0,1,0,1,1, 3,2));
    tv.push_back(mk(1,0,0,0,1, 0,  0,  0,0,b1,0,1,1,3,s1));
    tv.push_back(mk(1,0,0,1,0, 0,  0,  0,0,1,0,1,1, 3,2));
    tv.push_back(mk(1,1,0,0,0, 0,  0,  0,0,1,0,0,0, 0,2));
    tv.push_back(mk(1,1,0,0,1, 0,  0,  0,0,b1,0,1,0,1,s1));
    tv.push_back(mk(1,0,0,1,0, 0,  0,  0,0,1,0,1,0, 1,2));
    tv.push_back(mk(1,0,1,0,0, 0,  0,  0,0,1,1,1,0, 1,2));
    tv.push_back(mk(0,0,0,0,0, 0,  0,  0,0,0,0,1,0, 1,0));

    idle_in(0, '0);
    #12;
    check("reset", pack(0,0,0,0,0,0, '0, 2'd0));
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < tv.size(); i++) begin
      for (int g = 0; g < tv[i].gap; g++) begin
        @(negedge clk);
        idle_in(tv[i].en, tv[i].ncyc);
      end
      @(negedge clk);
      en = tv[i].en; clr = tv[i].clr; commit = tv[i].commit;
      trig = tv[i].trig; cyc = tv[i].cyc; ncyc = tv[i].ncyc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            pack(tv[i].rd, tv[i].sw, tv[i].bs, tv[i].sh,
                 tv[i].ur, tv[i].ov, tv[i].cnt, tv[i].st));
    end

    // Asynchronous reset in the middle of PLAY
    @(negedge clk); idle_in(1, 16'd1); commit = 1;
    @(negedge clk); idle_in(1, 16'd1); trig = 1;
    @(negedge clk); idle_in(1, 16'd1); commit = 1;
    @(posedge clk); #1;
    check("pre_rst_play", pack(1,0,1,1,1,0, 2'd1, 2'd2));
    #2 rst = 1;
    #1 check("async_rst", pack(0,0,0,0,0,0, '0, 2'd0));
    @(negedge clk);
    idle_in(1, 16'd2);
    rst = 0;

    model_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      en     = ($urandom_range(0, 63) != 0);
      clr    = ($urandom_range(0, 99) == 0);
      commit = ($urandom_range(0, 7) == 0);
      trig   = ($urandom_range(0, 9) == 0);
      cyc    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) ncyc = CW'($urandom_range(0, 4));
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rand%0d", c),
            pack(m_rd, m_sw, m_st == 2, m_sh, m_ur, m_ov,
                 UW'(m_cnt), 2'(m_st)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/asg_bank_swap_ctrl.md
Name: asg_bank_swap_ctrl

Overview:
Ping-pong bank scheduler for one channel of the double-buffered arbitrary signal generator. The DAC table is split into two banks: one bank is played by the DAC read engine while software reloads the other.
- Software commits the reloaded (shadow) bank.
- The controller swaps banks only on a table-pass boundary after a programmed number of passes, so the output never tears.
- It flags underruns when no fresh bank is ready at the swap point.
- One instance sits per channel, between the sys-bus register block and the DAC read-pointer logic.

Parameters:
CYC_W, 16, width of passes-per-bank count and pass counter
UCNT_W, 16, width of saturating underrun counter

Ports:
dac_clk_i  in  1  DAC clock (125 MHz); the block's single clock
dac_rst_i  in  1  asynchronous, active-high reset
en_i  in  1  channel enable (register bit, level)
clr_i  in  1  pulse; clears sticky flags and underrun counter
commit_i  in  1  pulse; software finished writing bank wr_bank_o
trig_i  in  1  pulse; start playback (trigger source already selected upstream)
cyc_end_i  in  1  pulse from read engine; read pointer wrapped (one table pass done)
ncyc_i  in  CYC_W  passes per bank before swap; 0 treated as 1
rd_bank_o  out  1  bank currently addressed by the DAC read engine
wr_bank_o  out  1  bank software may write; always ~rd_bank_o
swap_o  out  1  one-cycle pulse when rd_bank_o toggles
busy_o  out  1  high in PLAY
shadow_full_o  out  1  committed bank waiting; software must not write
underrun_o  out  1  sticky; swap point reached with no committed bank
ovr_o  out  1  sticky; commit_i received while shadow_full_o=1
urun_cnt_o  out  UCNT_W  saturating underrun count
state_o  out  2  FSM state, for status readback

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except wr_bank_o=1; pass_cnt=0.
- All outputs are registered. A response appears one clock after the input is sampled.
- States: IDLE=0, WAIT_TRIG=1, PLAY=2. Encoding 3 is unreachable and recovers to IDLE.
- en_i=0 (any state, highest priority): next state IDLE; shadow_full and pass_cnt cleared; rd_bank_o retained; sticky flags retained.
- IDLE, en_i=1:
  - commit_i → rd_bank_o<=wr_bank_o, swap_o=1 → WAIT_TRIG.
  - trig_i and cyc_end_i are ignored.
- WAIT_TRIG:
  - trig_i → PLAY with pass_cnt=0.
  - commit_i sets shadow_full.
  - cyc_end_i is ignored.
- PLAY:
  - trig_i is ignored.
  - commit_i sets shadow_full.
  - On cyc_end_i with pass_cnt+1 < max(ncyc_i,1): pass_cnt++.
  - On cyc_end_i with pass_cnt+1 >= max(ncyc_i,1) (the swap point), let avail = shadow_full | commit_i (same-cycle commit counts):
    - avail=1: toggle rd_bank_o, swap_o=1, shadow_full<=0, pass_cnt<=0; stay PLAY.
    - avail=0: underrun. underrun_o<=1; urun_cnt_o increments, saturating at all-ones; pass_cnt<=0. Next state per Optional Feature.
- commit_i when shadow_full=1 (and not consumed by a swap the same cycle): ignored, ovr_o<=1.
- clr_i clears underrun_o, ovr_o and urun_cnt_o. If clr_i coincides with a new underrun or overrun event, the event wins.
- ncyc_i is sampled at each cyc_end_i; changes take effect at the next comparison.
- pass_cnt must never wrap. The comparison is done at CYC_W+1 bits.

Optional Feature:
ASG_SWAP_UNDERRUN_STOP_EN
- Defined: on underrun go to WAIT_TRIG. busy_o drops the next cycle and the read engine holds the output. Playback resumes on the next trig_i, replaying the same bank.
- Undefined: on underrun stay in PLAY and repeat the active bank for another ncyc_i passes; underrun is flagged only.

Test Plan:
1. Reset then en_i=1, commit_i → next cycle rd_bank_o=1, wr_bank_o=0, swap_o one-cycle pulse, state_o=1.
2. ncyc_i=3, trig_i, commit_i, then 3 cyc_end_i pulses spaced 100 clk → swap_o only after the 3rd pulse; rd_bank_o 1→0; shadow_full_o 1→0; busy_o stays 1.
3. ncyc_i=2, no commit, 2 cyc_end_i → underrun_o=1, urun_cnt_o=1, rd_bank_o unchanged. Without the macro busy_o stays 1; with the macro state_o=1 and busy_o=0.
4. commit_i in the same cycle as the swap-point cyc_end_i → swap occurs, shadow_full_o=0, ovr_o=0. Then two commit_i pulses with no cyc_end_i between → ovr_o=1.
5. ncyc_i=0 → swap at every cyc_end_i when committed. Force UCNT_W=2 with 5 underruns → urun_cnt_o=3. clr_i → 0.
6. en_i dropped mid-PLAY with shadow_full_o=1 → next cycle state_o=0, shadow_full_o=0, rd_bank_o retained. Async dac_rst_i mid-PLAY → outputs return to reset values immediately.
